// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: a prescaler divides clk into count ticks, and an
// IDLE/RUN/PAUSE/DONE controller gates counting and saturates at 9999.
module stopwatch_ctrl #(
  parameter int PRESCALE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [3:0] o_d0,
  output logic [3:0] o_d1,
  output logic [3:0] o_d2,
  output logic [3:0] o_d3,
  output logic       o_running,
  output logic       o_done
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PS_W-1:0]   r_presc;
  logic [PS_W-1:0]   w_presc_nxt;
  logic [15:0]       r_digits;
  logic [15:0]       w_digits_nxt;
  logic              w_tick;
  logic              w_all9;

  // Decade cascade: a digit advances only while the carry is still alive;
  // anything at 9 (or corrupt above it) folds back to 0 and passes the carry on.
  function automatic logic [15:0] bcd_inc(input logic [15:0] d);
    logic [15:0] res;
    logic        carry;
    res   = d;
    carry = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (d[4*k +: 4] >= 4'd9) begin
          res[4*k +: 4] = 4'd0;
        end else begin
          res[4*k +: 4] = d[4*k +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

  assign w_tick = (r_state == ST_RUN) && (r_presc == PS_MAX);
  assign w_all9 = (r_digits == 16'h9999);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_digits <= '0;
    end else begin
      r_presc  <= w_presc_nxt;
      r_digits <= w_digits_nxt;
    end
  end

  // Clear wins over everything; otherwise a tick is applied first and the
  // start/stop command then acts on the pre-edge state, unless the tick saturated.
  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_digits_nxt = r_digits;
    if (i_clear) begin
      w_state_nxt  = ST_IDLE;
      w_presc_nxt  = '0;
      w_digits_nxt = '0;
    end else begin
      if (r_state == ST_RUN) begin
        w_presc_nxt = w_tick ? '0 : r_presc + PS_W'(1);
      end
      if (w_tick) begin
        if (w_all9) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_digits_nxt = bcd_inc(r_digits);
        end
      end
      if (i_start_stop && (w_state_nxt != ST_DONE)) begin
        case (r_state)
          ST_IDLE:  w_state_nxt = ST_RUN;
          ST_RUN:   w_state_nxt = ST_PAUSE;
          ST_PAUSE: w_state_nxt = ST_RUN;
          default:  w_state_nxt = r_state;
        endcase
      end
    end
  end

  assign o_d0      = r_digits[3:0];
  assign o_d1      = r_digits[7:4];
  assign o_d2      = r_digits[11:8];
  assign o_d3      = r_digits[15:12];
  assign o_running = (r_state == ST_RUN);
  assign o_done    = (r_state == ST_DONE);

endmodule
